// File: rtl/qosc_core.sv
// Quadrature square-wave oscillator with double-buffered quarter-period reload.
// Phase register drives (o_i,o_q) directly; updates land only on quarter boundaries.
module qosc_core #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_reload,
  output logic             o_i,
  output logic             o_q,
  output logic             o_step,
  output logic             o_cycle,
  output logic             o_running
);

  localparam logic [1:0] S0 = 2'b00;
  localparam logic [1:0] S1 = 2'b10;
  localparam logic [1:0] S2 = 2'b11;
  localparam logic [1:0] S3 = 2'b01;

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic [WIDTH-1:0] active;
  logic [WIDTH-1:0] pending;
  logic             pending_valid;
  logic [WIDTH-1:0] count;
  logic [1:0]       phase;
  logic [1:0]       phase_nxt;
  logic [WIDTH-1:0] next_len;
  logic             step_q;
  logic             cycle_q;
  logic             run_q;

  always_comb begin
    phase_nxt = S0;
    unique case (phase)
      S0: phase_nxt = S1;
      S1: phase_nxt = S2;
      S2: phase_nxt = S3;
      S3: phase_nxt = S0;
    endcase
  end

  // Bypass write beats the buffered value, which beats the current length.
  always_comb begin
    next_len = active;
    if (i_we)
      next_len = i_reload;
    else if (pending_valid)
      next_len = pending;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      active        <= ZERO;
      pending       <= ZERO;
      pending_valid <= 1'b0;
      count         <= ZERO;
      phase         <= S0;
      step_q        <= 1'b0;
      cycle_q       <= 1'b0;
      run_q         <= 1'b0;
    end else begin
      step_q  <= 1'b0;
      cycle_q <= 1'b0;
      if (active == ZERO) begin
        if (i_we && i_reload != ZERO) begin
          active        <= i_reload;
          count         <= i_reload - ONE;
          pending_valid <= 1'b0;
          run_q         <= 1'b1;
        end
      end else if (count != ZERO) begin
        count <= count - ONE;
        if (i_we) begin
          pending       <= i_reload;
          pending_valid <= 1'b1;
        end
      end else begin
        phase         <= phase_nxt;
        step_q        <= 1'b1;
        cycle_q       <= (phase == S3);
        active        <= next_len;
        count         <= (next_len == ZERO) ? ZERO : next_len - ONE;
        pending_valid <= 1'b0;
        run_q         <= (next_len != ZERO);
      end
    end
  end

  assign o_i       = phase[1];
  assign o_q       = phase[0];
  assign o_step    = step_q;
  assign o_cycle   = cycle_q;
  assign o_running = run_q;

endmodule

// File: tb/tb_qosc_core.sv
// Directed bench for qosc_core.
// Observed vector is {o_i, o_q, o_step, o_cycle, o_running}.
module tb_qosc_core;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [31:0] reload;
  logic        o_i;
  logic        o_q;
  logic        o_step;
  logic        o_cycle;
  logic        o_running;

  int checks = 0;
  int passes = 0;

  qosc_core #(.WIDTH(32)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_we      (we),
    .i_reload  (reload),
    .o_i       (o_i),
    .o_q       (o_q),
    .o_step    (o_step),
    .o_cycle   (o_cycle),
    .o_running (o_running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [4:0] exp);
    logic [4:0] got;
    got = {o_i, o_q, o_step, o_cycle, o_running};
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  task automatic wr(input logic [31:0] v);
    we     = 1'b1;
    reload = v;
    tick(1);
    we     = 1'b0;
    reload = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
  endtask

  // Output vector right after the k-th advance from S0 (running).
  function automatic logic [4:0] adv(input int k);
    logic [4:0] r;
    case (k % 4)
      1:       r = 5'b10101;
      2:       r = 5'b11101;
      3:       r = 5'b01101;
      default: r = 5'b00111;
    endcase
    return r;
  endfunction

  // Output vector while holding after the k-th advance (running).
  function automatic logic [4:0] hold(input int k);
    logic [4:0] r;
    r = adv(k);
    r[2] = 1'b0;
    r[1] = 1'b0;
    return r;
  endfunction

  initial begin
    rst_n  = 1'b0;
    we     = 1'b0;
    reload = '0;

    // Reset held 3 cycles, then idle with no writes
    tick(3);
    chk("reset_hold", 5'b00000);
    rst_n = 1'b1;
    tick(1);
    chk("reset_rel", 5'b00000);
    tick(10);
    chk("idle_halted", 5'b00000);

    // Halted write of 0 is a no-op
    wr(32'd0);
    chk("wr0_halted", 5'b00000);
    tick(3);
    chk("wr0_after", 5'b00000);

    // Reload 1: period 4, step every cycle
    wr(32'd1);
    chk("r1_start", 5'b00001);
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      chk($sformatf("r1_adv%0d", k), adv(k));
    end

    // Reload 3, then 5 written one cycle after a step
    do_reset();
    chk("r3_reset", 5'b00000);
    wr(32'd3);
    chk("r3_start", 5'b00001);
    for (int k = 1; k <= 16; k++) begin
      tick(2);
      chk($sformatf("r3_hold%0d", k), hold(k - 1));
      tick(1);
      chk($sformatf("r3_adv%0d", k), adv(k));
    end
    wr(32'd5);
    chk("r5_wr", hold(16));
    tick(1);
    chk("r5_old_q", hold(16));
    tick(1);
    chk("r5_adv17", adv(17));
    for (int k = 18; k <= 21; k++) begin
      tick(4);
      chk($sformatf("r5_hold%0d", k), hold(k - 1));
      tick(1);
      chk($sformatf("r5_adv%0d", k), adv(k));
    end

    // Terminal-cycle bypass: running at 4, write 7 on count==0
    do_reset();
    wr(32'd4);
    chk("bp_start", 5'b00001);
    tick(3);
    chk("bp_pre", 5'b00001);
    wr(32'd7);
    chk("bp_adv1", adv(1));
    tick(6);
    chk("bp_hold1", hold(1));
    tick(1);
    chk("bp_adv2", adv(2));
    tick(6);
    chk("bp_hold2", hold(2));
    tick(1);
    chk("bp_adv3", adv(3));

    // Halt and resume
    do_reset();
    wr(32'd2);
    chk("hr_start", 5'b00001);
    tick(1);
    chk("hr_cnt0", 5'b00001);
    tick(1);
    chk("hr_s1", adv(1));
    wr(32'd0);
    chk("hr_wr0", hold(1));
    tick(1);
    chk("hr_s2_halt", 5'b11100);
    tick(1);
    chk("hr_hold_a", 5'b11000);
    tick(8);
    chk("hr_hold_b", 5'b11000);
    wr(32'd2);
    chk("hr_resume", 5'b11001);
    tick(1);
    chk("hr_wait", 5'b11001);
    tick(1);
    chk("hr_s3", adv(3));

    // Reset mid-run with a pending 9
    do_reset();
    wr(32'd6);
    chk("rm_start", 5'b00001);
    tick(6);
    chk("rm_s1", adv(1));
    tick(6);
    chk("rm_s2", adv(2));
    wr(32'd9);
    chk("rm_pend", hold(2));
    rst_n = 1'b0;
    tick(1);
    chk("rm_reset", 5'b00000);
    rst_n = 1'b1;
    tick(1);
    chk("rm_rel", 5'b00000);
    tick(20);
    chk("rm_idle", 5'b00000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/qosc_core.md
# qosc_core

Quadrature square-wave local oscillator for the SDR front end. It takes the 32-bit reload word and write strobe produced by the UART configuration stage and generates in-phase and quadrature square waves 90° apart. Each quarter period lasts exactly `reload` clock cycles. Reload updates are double-buffered and take effect only on a quarter-period boundary, so the outputs never glitch or produce a truncated phase.

## Interface
- `WIDTH`, default 32: reload and counter width in bits.
- `i_clk`  input  1  system clock; all logic on its rising edge.
- `i_rst_n`  input  1  synchronous, active-low reset.
- `i_we`  input  1  single-cycle strobe; `i_reload` is valid in this cycle.
- `i_reload`  input  WIDTH  quarter-period length in clock cycles; 0 means halt.
- `o_i`  output  1  in-phase square wave.
- `o_q`  output  1  quadrature square wave, lagging `o_i` by 90°.
- `o_step`  output  1  one-cycle pulse on every phase advance.
- `o_cycle`  output  1  one-cycle pulse on the S3→S0 advance (full period done).
- `o_running`  output  1  high while the active reload is nonzero.

## Operation
- **Registers**
  - `active` (WIDTH): current quarter-period length.
  - `pending` (WIDTH) plus `pending_valid`: buffered next reload value.
  - `count` (WIDTH): down-counter.
  - `phase` (2 bits): quadrature state.
- **Phase states**, with (`o_i`,`o_q`) driven directly from the phase register:
  - S0 = (0,0)
  - S1 = (1,0)
  - S2 = (1,1)
  - S3 = (0,1)
  - Advance order is S0→S1→S2→S3→S0.
- **Write while running** (`active`≠0): `pending`<=`i_reload`, `pending_valid`<=1. Back-to-back writes overwrite `pending`; the last write wins.
- **Write while halted** (`active`==0): the value is applied immediately.
  - `active`<=`i_reload`, `count`<=`i_reload`-1.
  - `phase` is unchanged.
  - `pending_valid`<=0.
  - Writing 0 while halted is a no-op.
- **Running, `count`≠0**: `count` decrements by 1.
- **Running, `count`==0 (terminal cycle)**:
  - `phase` advances; `o_step` pulses; `o_cycle` pulses if the advance is S3→S0.
  - The next length is chosen by priority: `i_reload` if `i_we` is asserted this cycle (bypass), else `pending` if `pending_valid`, else `active`.
  - `active`<=next length, `count`<=next-1, `pending_valid`<=0.
- **Next length of 0**: `active`<=0 and `count`<=0. The oscillator halts with the phase just advanced held; `o_running` falls at the same edge.
- **Arithmetic**: unsigned WIDTH bits. next-1 is computed only for next≠0, so there is no wrap.
- **Reload value 1**: `count` stays 0 and the phase advances every cycle. The output period is 4 cycles, the minimum.

## Timing
- **Reset** (`i_rst_n` low at an edge), taking priority over everything:
  - `active`=0, `pending`=0, `pending_valid`=0, `count`=0, `phase`=S0.
  - `o_i`=0, `o_q`=0, `o_step`=0, `o_cycle`=0, `o_running`=0.
- **Reset mid-run**: the outputs return to S0 values at the reset edge. Any pending value is discarded.
- All outputs are registered.
- `o_running` goes high at the edge that samples a nonzero write while halted.
- **Latency from halted**:
  - A write of N sampled at edge t produces the first phase advance at edge t+N.
  - Steady state: one advance every N edges; full period 4N cycles.
- **Update latency while running**: a write takes effect at the next terminal edge. No advance is shortened or lengthened retroactively.
- **Write coincident with terminal cycle**: the bypass value governs the very next quarter. `pending_valid` ends at 0.
- `o_step` and `o_cycle` are high exactly in the cycle after the advancing edge, i.e. aligned with the new (`o_i`,`o_q`) values.

## Test plan
- **Reset**: hold `i_rst_n`=0 for 3 cycles, then release with no writes → all outputs 0; `o_running`=0 indefinitely.
- **Reload 1**: write 1 → `o_i`/`o_q` follow 00,10,11,01 repeating with period 4; `o_step` high every cycle; `o_cycle` once per 4.
- **Change 3→5 mid-run**: write 3; after 4 full periods, write 5 one cycle after a step → the current quarter still lasts 3 cycles, then every quarter lasts 5 cycles.
- **Terminal-cycle bypass**: running at 4, assert `i_we` with 7 exactly on a `count`==0 cycle → the next quarter lasts 7 cycles.
- **Halt and resume**:
  - Running at 2 in S1, write 0 → one more advance to S2, then `o_running`=0 and the outputs hold 11.
  - Then write 2 → the advance to S3 occurs 2 edges later.
- **Reset mid-run**: assert reset during S2 at reload 6 with a pending write of 9 → the outputs return to 00, `o_running`=0, and the 9 is never applied.
